// File: rtl/cv32e40x_xif_aes_sched_if.sv
// ---------------------------------------------------------------------------
// cv32e40x_xif_aes_sched_if
//
// Bundles the XIF issue, commit and result channels and the AES32 FU port of
// the AES32 scheduler. Signal suffixes are named from the scheduler's side:
// _i is driven toward the scheduler and _o is driven by it.
//
// Modports:
//   slave  - the scheduler (cv32e40x_xif_aes_sched)
//   master - the environment: core-side XIF and the AES32 functional unit
//
// Handshakes:
//   issue  : a request moves on issue_valid_i && issue_accept_o. Accept is
//            only given while issue_ready_o is high.
//   commit : one commit or kill per cycle on commit_valid_i. No back-pressure.
//   fu     : fu_valid_o is held with stable operands until fu_ready_i.
//   result : result_valid_o is held with stable payload until result_ready_i.
//            It never drops without a handshake.
// ---------------------------------------------------------------------------
interface cv32e40x_xif_aes_sched_if #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFR_WIDTH = 32
);
    logic                   issue_valid_i;
    logic                   issue_ready_o;
    logic [31:0]            issue_instr_i;
    logic [X_ID_WIDTH-1:0]  issue_id_i;
    logic [X_RFR_WIDTH-1:0] issue_rs1_i;
    logic [X_RFR_WIDTH-1:0] issue_rs2_i;
    logic [1:0]             issue_rs_valid_i;
    logic                   issue_accept_o;
    logic                   commit_valid_i;
    logic [X_ID_WIDTH-1:0]  commit_id_i;
    logic                   commit_kill_i;
    logic                   fu_valid_o;
    logic [X_RFR_WIDTH-1:0] fu_rs1_o;
    logic [X_RFR_WIDTH-1:0] fu_rs2_o;
    logic [1:0]             fu_bs_o;
    logic [3:0]             fu_op_o;
    logic                   fu_ready_i;
    logic [X_RFR_WIDTH-1:0] fu_result_i;
    logic                   result_valid_o;
    logic                   result_ready_i;
    logic [X_ID_WIDTH-1:0]  result_id_o;
    logic [4:0]             result_rd_o;
    logic [X_RFR_WIDTH-1:0] result_data_o;
    logic                   busy_o;

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
               issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i,
               fu_ready_i, fu_result_i, result_ready_i,
        output issue_ready_o, issue_accept_o, fu_valid_o, fu_rs1_o, fu_rs2_o,
               fu_bs_o, fu_op_o, result_valid_o, result_id_o, result_rd_o,
               result_data_o, busy_o
    );

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
               issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i,
               fu_ready_i, fu_result_i, result_ready_i,
        input  issue_ready_o, issue_accept_o, fu_valid_o, fu_rs1_o, fu_rs2_o,
               fu_bs_o, fu_op_o, result_valid_o, result_id_o, result_rd_o,
               result_data_o, busy_o
    );
endinterface

// File: rtl/cv32e40x_xif_aes_sched.sv
// ---------------------------------------------------------------------------
// cv32e40x_xif_aes_sched
//
// Scheduler for the shared AES32 functional unit behind the XIF port.
// Accepted AES32 instructions sit in a DEPTH-entry circular FIFO of slots
// (FREE / ISSUED / COMMITTED / KILLED). Commits and kills are matched by ID;
// committed instructions go to the FU strictly in order from the head, and
// the FU result is buffered until the core's result channel takes it.
//
// Ports:
//   clk_i        clock
//   rst_n        asynchronous active-low reset
//   xif          issue / commit / fu / result channels (slave modport)
//   dbg_state_o  current FSM state (IDLE=0, EXEC=1, RESP=2)
//
// Optional feature macro: AES_SCHED_RESULT_BYPASS_EN
//   When defined, an FU result is presented on the result channel in the
//   same EXEC cycle it arrives; a same-cycle handshake skips RESP entirely.
// ---------------------------------------------------------------------------
module cv32e40x_xif_aes_sched #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_n,
    cv32e40x_xif_aes_sched_if.slave        xif,
    output logic [1:0]                     dbg_state_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_AES32 = 7'b0110011;
    localparam logic [4:0] F_ESI     = 5'b10001;
    localparam logic [4:0] F_ESMI    = 5'b10011;
    localparam logic [4:0] F_DSI     = 5'b10101;
    localparam logic [4:0] F_DSMI    = 5'b10111;

    localparam logic [1:0] SLOT_FREE      = 2'd0;
    localparam logic [1:0] SLOT_ISSUED    = 2'd1;
    localparam logic [1:0] SLOT_COMMITTED = 2'd2;
    localparam logic [1:0] SLOT_KILLED    = 2'd3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Only the instruction fields the FU and result path need are stored.
    logic [1:0]             slot_st    [DEPTH];
    logic [X_ID_WIDTH-1:0]  slot_id    [DEPTH];
    logic [1:0]             slot_bs    [DEPTH];
    logic [4:0]             slot_funct [DEPTH];
    logic [4:0]             slot_rd    [DEPTH];
    logic [X_RFR_WIDTH-1:0] slot_rs1   [DEPTH];
    logic [X_RFR_WIDTH-1:0] slot_rs2   [DEPTH];

    logic [PTR_W-1:0]       head, tail;
    logic [CNT_W-1:0]       count;
    logic [1:0]             state, state_nxt;
    logic [X_ID_WIDTH-1:0]  res_id;
    logic [4:0]             res_rd;
    logic [X_RFR_WIDTH-1:0] res_data;

    logic                   accept, same_cycle_commit, commit_hit, pop;
    logic [PTR_W-1:0]       commit_idx, idx;
    logic [4:0]             issue_funct;
    logic                   funct_ok;
    logic                   unused_instr_bits;

    assign unused_instr_bits = ^{xif.issue_instr_i[24:12]};

    assign issue_funct = xif.issue_instr_i[29:25];
    assign funct_ok    = (issue_funct == F_ESI) || (issue_funct == F_ESMI) ||
                         (issue_funct == F_DSI) || (issue_funct == F_DSMI);

    // Ready looks at the registered count only, so a pop cannot raise it early.
    assign xif.issue_ready_o = (count != CNT_W'(DEPTH));
    assign accept = xif.issue_valid_i && xif.issue_ready_o &&
                    (xif.issue_instr_i[6:0] == OPC_AES32) && funct_ok &&
                    (xif.issue_rs_valid_i == 2'b11);
    assign xif.issue_accept_o = accept;

    // A commit for the ID being accepted this cycle lands on the new slot.
    assign same_cycle_commit = accept && xif.commit_valid_i &&
                               (xif.commit_id_i == xif.issue_id_i);

    // Oldest-first search from head for an ISSUED slot with the committed ID.
    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (!commit_hit && slot_st[idx] == SLOT_ISSUED &&
                slot_id[idx] == xif.commit_id_i) begin
                commit_hit = 1'b1;
                commit_idx = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (slot_st[head] == SLOT_KILLED)         pop = 1'b1;
                else if (slot_st[head] == SLOT_COMMITTED) state_nxt = EXEC;
            end
            EXEC: begin
                if (xif.fu_ready_i) begin
`ifdef AES_SCHED_RESULT_BYPASS_EN
                    if (xif.result_ready_i) begin
                        pop       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RESP;
                    end
`else
                    state_nxt = RESP;
`endif
                end
            end
            RESP: begin
                if (xif.result_ready_i) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            res_id   <= '0;
            res_rd   <= '0;
            res_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_st[i]    <= SLOT_FREE;
                slot_id[i]    <= '0;
                slot_bs[i]    <= '0;
                slot_funct[i] <= '0;
                slot_rd[i]    <= '0;
                slot_rs1[i]   <= '0;
                slot_rs2[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            if (pop) begin
                slot_st[head] <= SLOT_FREE;
                head          <= head + PTR_W'(1);
            end
            if (accept) begin
                if (same_cycle_commit)
                    slot_st[tail] <= xif.commit_kill_i ? SLOT_KILLED : SLOT_COMMITTED;
                else
                    slot_st[tail] <= SLOT_ISSUED;
                slot_id[tail]    <= xif.issue_id_i;
                slot_bs[tail]    <= xif.issue_instr_i[31:30];
                slot_funct[tail] <= issue_funct;
                slot_rd[tail]    <= xif.issue_instr_i[11:7];
                slot_rs1[tail]   <= xif.issue_rs1_i;
                slot_rs2[tail]   <= xif.issue_rs2_i;
                tail             <= tail + PTR_W'(1);
            end
            if (xif.commit_valid_i && !same_cycle_commit && commit_hit)
                slot_st[commit_idx] <= xif.commit_kill_i ? SLOT_KILLED : SLOT_COMMITTED;
            if (accept && !pop)      count <= count + CNT_W'(1);
            else if (!accept && pop) count <= count - CNT_W'(1);
            if (state == EXEC && xif.fu_ready_i) begin
                res_id   <= slot_id[head];
                res_rd   <= slot_rd[head];
                res_data <= xif.fu_result_i;
            end
        end
    end

    // FU port: operands come straight from the head slot while in EXEC.
    always_comb begin
        xif.fu_valid_o = (state == EXEC);
        xif.fu_rs1_o   = '0;
        xif.fu_rs2_o   = '0;
        xif.fu_bs_o    = '0;
        xif.fu_op_o    = '0;
        if (state == EXEC) begin
            xif.fu_rs1_o = slot_rs1[head];
            xif.fu_rs2_o = slot_rs2[head];
            xif.fu_bs_o  = slot_bs[head];
            case (slot_funct[head])
                F_ESI:   xif.fu_op_o = 4'b0001;
                F_ESMI:  xif.fu_op_o = 4'b0010;
                F_DSI:   xif.fu_op_o = 4'b0100;
                F_DSMI:  xif.fu_op_o = 4'b1000;
                default: xif.fu_op_o = 4'b0000;
            endcase
        end
    end

    always_comb begin
        xif.result_valid_o = 1'b0;
        xif.result_id_o    = '0;
        xif.result_rd_o    = '0;
        xif.result_data_o  = '0;
        if (state == RESP) begin
            xif.result_valid_o = 1'b1;
            xif.result_id_o    = res_id;
            xif.result_rd_o    = res_rd;
            xif.result_data_o  = res_data;
        end
`ifdef AES_SCHED_RESULT_BYPASS_EN
        else if (state == EXEC && xif.fu_ready_i) begin
            xif.result_valid_o = 1'b1;
            xif.result_id_o    = slot_id[head];
            xif.result_rd_o    = slot_rd[head];
            xif.result_data_o  = xif.fu_result_i;
        end
`endif
    end

    assign xif.busy_o  = (count != '0) || (state != IDLE);
    assign dbg_state_o = state;

endmodule

// File: doc/cv32e40x_xif_aes_sched.md
Name: cv32e40x_xif_aes_sched

Overview:
- Scheduler and controller for the shared AES32 functional unit behind the XIF coprocessor port.
- Accepts up to DEPTH offloaded AES32 instructions from the issue interface and tracks the commit or kill of each by ID.
- Dispatches committed instructions in order to the single riscv_crypto_fu_saes32 instance.
- Buffers each FU result until the core's result interface accepts it.

Parameters:
- X_ID_WIDTH, 4: width of instruction ID.
- X_RFR_WIDTH, 32: operand and result width.
- DEPTH, 4: number of outstanding instruction slots; power of two, minimum 2.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset
- issue_valid_i  in  1  XIF issue request valid
- issue_ready_o  out  1  scheduler can take a request
- issue_instr_i  in  32  offloaded instruction word
- issue_id_i  in  X_ID_WIDTH  instruction ID
- issue_rs1_i  in  X_RFR_WIDTH  rs[0] value
- issue_rs2_i  in  X_RFR_WIDTH  rs[1] value
- issue_rs_valid_i  in  2  operand valid bits, bit0 = rs1
- issue_accept_o  out  1  request accepted; also used as writeback
- commit_valid_i  in  1  commit transaction valid
- commit_id_i  in  X_ID_WIDTH  ID being committed or killed
- commit_kill_i  in  1  1 = kill, 0 = commit
- fu_valid_o  out  1  FU operands valid
- fu_rs1_o  out  X_RFR_WIDTH  FU rs1
- fu_rs2_o  out  X_RFR_WIDTH  FU rs2
- fu_bs_o  out  2  byte select, instr[31:30]
- fu_op_o  out  4  one-hot op {decsm, decs, encsm, encs}
- fu_ready_i  in  1  FU result valid
- fu_result_i  in  X_RFR_WIDTH  FU result
- result_valid_o  out  1  XIF result valid
- result_ready_i  in  1  XIF result ready
- result_id_o  out  X_ID_WIDTH  result ID
- result_rd_o  out  5  destination register, instr[11:7]
- result_data_o  out  X_RFR_WIDTH  result data
- busy_o  out  1  any slot not FREE, or FSM not IDLE

Behaviour:
- Reset rst_n, asynchronous, active-low; clock clk_i.
- Reset state: all slots FREE, head and tail pointers 0, count 0, FSM IDLE, every output 0 except issue_ready_o = 1.
- Reset mid-operation discards all slots and any buffered result with no response.
- Slot states are FREE, ISSUED, COMMITTED, KILLED. The slots form a circular FIFO; pointers wrap modulo DEPTH.
- issue_ready_o = (count != DEPTH), from registered count only. A pop in the same cycle does not raise it.
- issue_accept_o is combinational and equals 1 when all of the following hold:
  - issue_valid_i and issue_ready_o;
  - instr[6:0] == AES32;
  - instr[29:25] is one of AES32ESI, AES32ESMI, AES32DSI, AES32DSMI;
  - issue_rs_valid_i == 2'b11.
- On accept, the tail slot captures instr, id, rs1 and rs2, and becomes ISSUED. The tail pointer increments.
- Requests that do not match are not accepted and are not stored.
- Commit handling:
  - commit_valid_i updates the oldest ISSUED slot whose id matches: kill sets it KILLED, otherwise it becomes COMMITTED.
  - If no ISSUED slot matches, the commit is ignored.
  - A commit in the same cycle as the accept of the same ID applies to the new slot, which is written directly as COMMITTED or KILLED.
- FSM IDLE:
  - head slot KILLED: pop it (slot FREE, head++), stay IDLE, no FU activity;
  - head slot COMMITTED: go to EXEC;
  - head slot ISSUED or FREE: wait.
- FSM EXEC:
  - fu_valid_o = 1, with fu_* driven from the head slot; fu_op_o is one-hot per funct[29:25];
  - fu_valid_o is held until fu_ready_i;
  - on fu_ready_i, capture fu_result_i, id and rd into the result buffer and go to RESP.
- FSM RESP:
  - result_valid_o = 1, with result_* held stable from the buffer until result_ready_i;
  - on the handshake, pop the head and return to IDLE;
  - result_valid_o never deasserts without a handshake.
- Push and pop in the same cycle leave count unchanged.
- Kills of later slots do not disturb the head in EXEC or RESP.
- Minimum latency with a combinational FU: commit in cycle C, EXEC in C+2, result_valid_o in C+3.

Optional Feature:
- Macro AES_SCHED_RESULT_BYPASS_EN.
- When defined: in EXEC with fu_ready_i, result_valid_o = 1 in the same cycle and result_data_o = fu_result_i.
  - If result_ready_i is also 1, pop and return to IDLE directly.
  - Otherwise capture and go to RESP.
  - Minimum latency becomes C+2.
- When undefined: always route through RESP as described in Behaviour.

Test Plan:
- Issue AES32ESI, id 3, rs1 = 0x00000000, rs2 = 0x00000052, bs 0; commit id 3 next cycle -> one EXEC with fu_op_o = 4'b0001; result_valid_o with id 3, rd = instr[11:7], data = fu_result_i, at C+3 (C+2 with bypass).
- Issue ids 1, 2, 3, 4 back-to-back with no commits -> 4th accepted, issue_ready_o = 0 on the 5th request, issue_accept_o = 0; commit and drain id 1 -> issue_ready_o = 1 the cycle after the pop.
- Issue ids 5, 6; kill id 5, commit id 6 -> no FU activity for 5, head popped in 1 cycle, exactly one result with id 6.
- Hold result_ready_i = 0 for 5 cycles in RESP -> result_valid_o, id and data stable all 5 cycles; pop occurs only on the handshake cycle.
- Issue with rs_valid = 2'b01, or a non-AES32 opcode -> issue_accept_o = 0, count unchanged.
- Assert rst_n low during EXEC with 3 slots occupied -> all outputs 0 and issue_ready_o = 1 immediately; no result is emitted after reset release.
